// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and uart_drive-side handshake signals for uart_tx_arbiter.
// slave = arbiter view, master = user logic / uart_drive view.
`default_nettype none

interface uart_tx_arbiter_if #(
    parameter int P_REQ_NUM    = 4,
    parameter int P_DATA_WIDTH = 8
);
    logic [P_REQ_NUM*P_DATA_WIDTH-1:0] i_req_data;
    logic [P_REQ_NUM-1:0]              i_req_valid;
    logic [P_REQ_NUM-1:0]              i_req_last;
    logic [P_REQ_NUM-1:0]              o_req_ready;
    logic [P_DATA_WIDTH-1:0]           o_user_tx_data;
    logic                              o_user_tx_valid;
    logic                              i_user_tx_ready;
    logic [P_REQ_NUM-1:0]              o_grant;
    logic                              o_force_release;

    modport slave (
        input  i_req_data, i_req_valid, i_req_last, i_user_tx_ready,
        output o_req_ready, o_user_tx_data, o_user_tx_valid, o_grant, o_force_release
    );

    modport master (
        output i_req_data, i_req_valid, i_req_last, i_user_tx_ready,
        input  o_req_ready, o_user_tx_data, o_user_tx_valid, o_grant, o_force_release
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of the uart_drive transmit port.
// Revision 1.0 - initial release.
`default_nettype none

module uart_tx_arbiter #(
    parameter int P_REQ_NUM    = 4,
    parameter int P_DATA_WIDTH = 8,
    parameter int P_MAX_BYTES  = 64
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst_n,
    uart_tx_arbiter_if.slave    bus
);
    localparam int c_IDX_W = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;
    localparam int c_CNT_W = $clog2(P_MAX_BYTES + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_gnt;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [c_IDX_W-1:0]   w_sel;
    logic [P_REQ_NUM-1:0] w_onehot;
    logic                 w_lock;
    logic                 w_xfer;
    logic                 w_last;
    logic                 w_limit;

    // Scan downward so the lowest offset from r_ptr is the last (winning) assignment.
    always_comb begin : p_rr_select
        int j;
        w_sel = r_ptr;
        j     = 0;
        for (int i = P_REQ_NUM - 1; i >= 0; i--) begin
            j = int'(r_ptr) + i;
            if (j >= P_REQ_NUM) begin
                j = j - P_REQ_NUM;
            end
            if (bus.i_req_valid[j]) begin
                w_sel = c_IDX_W'(j);
            end
        end
    end

    assign w_lock   = (r_state == S_LOCK);
    assign w_onehot = P_REQ_NUM'(1) << r_gnt;
    assign w_last   = bus.i_req_last[r_gnt];
    assign w_limit  = (r_cnt == c_CNT_W'(P_MAX_BYTES - 1));
    assign w_xfer   = bus.o_user_tx_valid & bus.i_user_tx_ready;

    assign bus.o_grant         = w_lock ? w_onehot : '0;
    assign bus.o_user_tx_valid = w_lock & bus.i_req_valid[r_gnt];
    assign bus.o_user_tx_data  = w_lock ? bus.i_req_data[r_gnt*P_DATA_WIDTH +: P_DATA_WIDTH] : '0;
    assign bus.o_req_ready     = (w_lock && bus.i_user_tx_ready) ? w_onehot : '0;
    // A real last byte on the limit transfer is a normal end, not a forced one.
    assign bus.o_force_release = w_xfer & w_limit & ~w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|bus.i_req_valid) begin
                        r_gnt   <= w_sel;
                        r_cnt   <= '0;
                        r_state <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (w_xfer) begin
                        if (w_last || w_limit) begin
                            r_state <= S_IDLE;
                            r_ptr   <= (r_gnt == c_IDX_W'(P_REQ_NUM - 1)) ? '0 : r_gnt + 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner cases, random traffic.
`default_nettype none

module tb_uart_tx_arbiter;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXB = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.P_REQ_NUM(N), .P_DATA_WIDTH(W)) bus();

    uart_tx_arbiter #(.P_REQ_NUM(N), .P_DATA_WIDTH(W), .P_MAX_BYTES(MAXB)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: current owner (-1 = none), next search start, bytes sent this grant.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    logic [N-1:0] obs_grant, obs_rdy;
    logic         obs_v, obs_force;
    logic [W-1:0] obs_data;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic [W-1:0] d2;
        logic         rdy;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         ev;
        logic [W-1:0] ed;
        logic         ef;
    } vec_t;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
    endfunction

    function automatic void model_expect(output logic [N-1:0] eg, output logic [N-1:0] er,
                                         output logic ev, output logic [W-1:0] ed, output logic ef);
        eg = '0; er = '0; ev = 1'b0; ed = '0; ef = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ev = bus.i_req_valid[m_owner];
            ed = bus.i_req_data[m_owner*W +: W];
            if (bus.i_user_tx_ready) er = eg;
            ef = ev && bus.i_user_tx_ready && !bus.i_req_last[m_owner] && (m_cnt + 1 == MAXB);
        end
    endfunction

    function automatic void model_update();
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && bus.i_req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            end
            m_cnt = 0;
        end else if (bus.i_req_valid[m_owner] && bus.i_user_tx_ready) begin
            m_cnt++;
            if (bus.i_req_last[m_owner] || m_cnt == MAXB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endfunction

    function automatic int oh_idx(logic [N-1:0] v);
        int r = -1;
        for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    task automatic check(input string tag, input logic [N-1:0] eg, input logic [N-1:0] er,
                         input logic ev, input logic [W-1:0] ed, input logic ef);
        vectors++;
        if (bus.o_grant !== eg || bus.o_req_ready !== er || bus.o_user_tx_valid !== ev ||
            bus.o_user_tx_data !== ed || bus.o_force_release !== ef) begin
            miscompares++;
            $display("FAIL %s @%0t: got grant=%b ready=%b valid=%b data=%h force=%b, expected grant=%b ready=%b valid=%b data=%h force=%b",
                     tag, $time, bus.o_grant, bus.o_req_ready, bus.o_user_tx_valid,
                     bus.o_user_tx_data, bus.o_force_release, eg, er, ev, ed, ef);
        end
    endtask

    task automatic cmp_int(input string tag, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Called just after a negedge with inputs already applied; returns the model's transferring owner.
    task automatic step(input string tag, output int xo);
        logic [N-1:0] eg, er;
        logic         ev, ef;
        logic [W-1:0] ed;
        #1;
        model_expect(eg, er, ev, ed, ef);
        check(tag, eg, er, ev, ed, ef);
        obs_grant = bus.o_grant;
        obs_rdy   = bus.o_req_ready;
        obs_v     = bus.o_user_tx_valid;
        obs_data  = bus.o_user_tx_data;
        obs_force = bus.o_force_release;
        xo = (ev && bus.i_user_tx_ready) ? m_owner : -1;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_lane(input int k, input logic [W-1:0] v);
        bus.i_req_data[k*W +: W] = v;
    endtask

    task automatic do_reset();
        rst_n               = 1'b0;
        bus.i_req_valid     = '1;
        bus.i_req_last      = '0;
        bus.i_req_data      = '1;
        bus.i_user_tx_ready = 1'b1;
        #1;
        check("reset", '0, '0, 1'b0, '0, 1'b0);
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl [8];
        int    xo;
        int    order [$];
        int    exp_rr [6];
        int    exp_fr [3];
        logic [N-1:0] prev;
        int    sent0, force_cnt, force_at, viol, leak;
        bit    pend [N];

        // Requester 2 alone, 3-byte packet, downstream ready toggling.
        tbl[0] = '{4'b0100, 4'b0000, 8'h41, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{4'b0100, 4'b0000, 8'h41, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'h41, 1'b0};
        tbl[2] = '{4'b0100, 4'b0000, 8'h42, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'h42, 1'b0};
        tbl[3] = '{4'b0100, 4'b0000, 8'h42, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'h42, 1'b0};
        tbl[4] = '{4'b0100, 4'b0100, 8'h43, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'h43, 1'b0};
        tbl[5] = '{4'b0100, 4'b0100, 8'h43, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'h43, 1'b0};
        tbl[6] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
        tbl[7] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
        exp_rr = '{0, 1, 3, 0, 1, 3};
        exp_fr = '{0, 1, 0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.i_req_valid     = tbl[i].valid;
            bus.i_req_last      = tbl[i].last;
            bus.i_req_data      = {8'hE3, tbl[i].d2, 8'hE1, 8'hE0};
            bus.i_user_tx_ready = tbl[i].rdy;
            #1;
            check($sformatf("table[%0d]", i), tbl[i].eg, tbl[i].er, tbl[i].ev, tbl[i].ed, tbl[i].ef);
            @(posedge clk);
            @(negedge clk);
        end

        // Round robin among 0, 1, 3 with back-to-back 1-byte packets.
        do_reset();
        for (int k = 0; k < N; k++) set_lane(k, 8'(8'h10 + k));
        bus.i_req_valid = 4'b1011;
        bus.i_req_last  = 4'b1011;
        prev = '0;
        viol = 0;
        for (int c = 0; c < 20; c++) begin
            step("rr", xo);
            if (obs_grant != '0 && prev == '0) order.push_back(oh_idx(obs_grant));
            if (obs_grant != '0 && prev != '0) viol++;
            prev = obs_grant;
        end
        for (int k = 0; k < 6; k++)
            cmp_int($sformatf("rr_order[%0d]", k), (k < order.size()) ? order[k] : -1, exp_rr[k]);
        cmp_int("rr_no_gap_violations", viol, 0);

        // Requester 0 streams 100 bytes with no last; requester 1 waits with a 1-byte packet.
        do_reset();
        order.delete();
        sent0 = 0; force_cnt = 0; force_at = -1; prev = '0;
        set_lane(1, 8'hB1);
        bus.i_req_last = 4'b0010;
        bus.i_req_valid[1] = 1'b1;
        for (int c = 0; c < 140; c++) begin
            set_lane(0, 8'(sent0));
            bus.i_req_valid[0] = (sent0 < 100);
            step("force", xo);
            if (xo == 0) sent0++;
            if (xo == 1) bus.i_req_valid[1] = 1'b0;
            if (obs_force) begin
                force_cnt++;
                force_at = sent0;
            end
            if (obs_grant != '0 && prev == '0) order.push_back(oh_idx(obs_grant));
            prev = obs_grant;
        end
        cmp_int("force_pulses", force_cnt, 1);
        cmp_int("force_at_byte", force_at, 64);
        cmp_int("force_bytes_total", sent0, 100);
        for (int k = 0; k < 3; k++)
            cmp_int($sformatf("force_order[%0d]", k), (k < order.size()) ? order[k] : -1, exp_fr[k]);

        // Owner 1 drops valid mid-packet while requester 2 is waiting.
        do_reset();
        viol = 0; leak = 0;
        set_lane(1, 8'hA0);
        set_lane(2, 8'hC2);
        bus.i_req_last  = 4'b0100;
        bus.i_req_valid = 4'b0010;
        step("drop", xo);
        step("drop", xo);
        bus.i_req_valid = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            step("drop", xo);
            if (obs_grant !== 4'b0010 || obs_rdy[2] !== 1'b0) viol++;
            if (obs_v && obs_data == 8'hC2) leak++;
        end
        bus.i_req_valid = 4'b0110;
        set_lane(1, 8'hA1);
        step("drop", xo);
        if (obs_v && obs_data == 8'hC2) leak++;
        set_lane(1, 8'hA2);
        bus.i_req_last = 4'b0110;
        step("drop", xo);
        if (obs_v && obs_data == 8'hC2) leak++;
        bus.i_req_valid = 4'b0100;
        step("drop", xo);
        cmp_int("drop_idle_after_last", int'(obs_grant), 0);
        step("drop", xo);
        cmp_int("drop_next_grant", int'(obs_grant), 4);
        cmp_int("drop_grant_violations", viol, 0);
        cmp_int("drop_leaked_bytes", leak, 0);

        // Asynchronous reset in the middle of byte 2 of a 4-byte packet.
        do_reset();
        bus.i_req_valid = 4'b1000;
        bus.i_req_last  = 4'b0000;
        set_lane(3, 8'hD0);
        step("rst_mid", xo);
        step("rst_mid", xo);
        set_lane(3, 8'hD1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", '0, '0, 1'b0, '0, 1'b0);
        model_reset();
        bus.i_req_valid = 4'b1110;
        bus.i_req_last  = 4'b1110;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_after", xo);
        step("rst_after", xo);
        cmp_int("rst_first_grant", int'(obs_grant), 2);

        // Random traffic; requester 3 never marks last so forced releases occur.
        do_reset();
        bus.i_req_valid = '0;
        bus.i_req_last  = '0;
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 3) == 0) begin
                    pend[k] = 1'b1;
                    set_lane(k, 8'($urandom));
                    bus.i_req_last[k] = (k != 3) && ($urandom_range(0, 3) == 0);
                end
                bus.i_req_valid[k] = pend[k];
            end
            bus.i_user_tx_ready = ($urandom_range(0, 3) != 0);
            step("random", xo);
            if (xo >= 0) pend[xo] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares the single transmit user port of `uart_drive` (`i_user_tx_data` / `i_user_tx_valid` / `o_user_tx_ready`) between up to eight byte-stream requesters.
- Arbitration is round-robin at packet granularity: a granted requester keeps the port until it marks its last byte, or until a forced release after `P_MAX_BYTES` bytes. This stops bytes from different sources interleaving on the serial line.
- Sits between user logic and `uart_drive` in the 50 MHz domain of `UART_TOP`.

## Interface
Parameters:
- `P_REQ_NUM`, 4 — number of requesters, legal range 2..8.
- `P_DATA_WIDTH`, 8 — byte width; must match `P_UART_DATA_WIDTH` of `uart_drive`.
- `P_MAX_BYTES`, 64 — bytes per grant before forced release, legal range 1..255.

Ports:
- `i_clk` input 1 — system clock. One clock domain only.
- `i_rst_n` input 1 — reset, asynchronous assert, active-low.
- `i_req_data` input `P_REQ_NUM*P_DATA_WIDTH` — requester k's byte is `[k*P_DATA_WIDTH +: P_DATA_WIDTH]`.
- `i_req_valid` input `P_REQ_NUM` — per-requester byte valid.
- `i_req_last` input `P_REQ_NUM` — per-requester last byte of packet; sampled only on a transfer.
- `o_req_ready` output `P_REQ_NUM` — per-requester ready.
- `o_user_tx_data` output `P_DATA_WIDTH` — to `uart_drive` `i_user_tx_data`.
- `o_user_tx_valid` output 1 — to `uart_drive` `i_user_tx_valid`.
- `i_user_tx_ready` input 1 — from `uart_drive` `o_user_tx_ready`.
- `o_grant` output `P_REQ_NUM` — one-hot current owner; all zero when idle.
- `o_force_release` output 1 — one-cycle pulse when a grant ends on the `P_MAX_BYTES` limit.

## Operation
- **Transfer rule**
  - Downstream transfer occurs when `o_user_tx_valid && i_user_tx_ready`.
  - Requester k transfers when `i_req_valid[k] && o_req_ready[k]`.
  - These two events are the same cycle.
- **State machine:** two states, IDLE and LOCK. Registers: grant index `r_gnt`, priority pointer `r_ptr`, byte counter `r_cnt`.
- **IDLE**
  - `o_grant` = 0, `o_user_tx_valid` = 0, `o_req_ready` = 0.
  - If any `i_req_valid` bit is set: select the first set bit searching upward from `r_ptr` with wrap-around, register it in `r_gnt`, clear `r_cnt`, go to LOCK.
- **LOCK**
  - `o_grant` = one-hot(`r_gnt`).
  - `o_user_tx_data` = data of `r_gnt`; `o_user_tx_valid` = `i_req_valid[r_gnt]`.
  - `o_req_ready[r_gnt]` = `i_user_tx_ready`; all other ready bits are 0.
  - All of these are combinational from `r_gnt`.
  - On each transfer, `r_cnt` increments.
- **Release from LOCK:** on the transfer where `i_req_last[r_gnt]` = 1 or `r_cnt` = `P_MAX_BYTES-1`, go to IDLE and set `r_ptr` = (`r_gnt`+1) mod `P_REQ_NUM`.
  - If `last` is 0 on that transfer (limit reached), pulse `o_force_release` for that cycle.
  - If `last` = 1 and the limit is reached on the same transfer, there is no pulse.
- **Grant stability**
  - The owner keeps the grant while its valid is low mid-packet; there is no timeout on an idle owner.
  - Other requesters' valids never affect ownership while in LOCK.
- `r_cnt` width is `clog2(P_MAX_BYTES+1)`. `r_cnt` never exceeds `P_MAX_BYTES-1`.
- Downstream data/valid follow the requester combinationally. Requesters must hold data and valid stable until transfer; the arbiter does no buffering.

## Timing
- **Reset values**
  - State = IDLE, `r_ptr` = 0, `r_gnt` = 0, `r_cnt` = 0.
  - Outputs: `o_grant` = 0, `o_req_ready` = 0, `o_user_tx_valid` = 0, `o_user_tx_data` = 0, `o_force_release` = 0.
  - IDLE forces data to 0.
- **Latency:** a request in IDLE at cycle N gives `o_grant` and `o_user_tx_valid` at cycle N+1. There is zero combinational path from `i_req_valid` to `o_grant`.
- **Inter-packet gap:** exactly one IDLE cycle between release and the next grant, including when the same requester re-requests.
- **Throughput:** one byte per cycle in which `uart_drive` is ready. At 9600 baud, the arbiter is never the bottleneck.
- **Reset mid-packet:** asserting `i_rst_n` low returns to IDLE immediately. The partial packet is abandoned; the requester must restart it.
- **Simultaneous events:** a new request arriving on the release cycle is considered in the following IDLE cycle with the updated `r_ptr`.

## Test plan
- Requester 2 alone sends a 3-byte packet (0x41, 0x42, 0x43, `last` on 0x43), `i_user_tx_ready` toggling 1/0 → bytes appear in order on `o_user_tx_data`, `o_grant` = 4'b0100 throughout, then IDLE one cycle.
- Requesters 0, 1 and 3 hold 1-byte packets continuously from reset → grants in order 0, 1, 3, 0, 1, 3, with one IDLE cycle between each grant.
- Requester 0 streams 100 bytes, `last` never set, `P_MAX_BYTES` = 64 → `o_force_release` pulses on the 64th transfer; requester 1 (pending) is granted next; requester 0 regains the grant afterwards.
- Requester 1 drops valid for 20 cycles mid-packet while requester 2 is valid → `o_grant` stays 4'b0010, `o_req_ready[2]` stays 0, and no byte from requester 2 appears before requester 1's `last`.
- `i_rst_n` pulsed low during byte 2 of a 4-byte packet → all outputs reach their reset values without waiting for `i_clk`. After release, the lowest valid index is granted first.
- Integrated with `uart_drive` at 9600 baud: two requesters send "AB" and "CD" → serial line carries either A,B,C,D or C,D,A,B, never interleaved.
